// File: rtl/wb_user_module_stepper_pkg.sv
// Shared definitions for the Wishbone user-module stepper.
//   - register offsets (word offsets, adr[7:2])
//   - STATUS field positions
//   - burst FSM state encodings
//   - byte-lane merge helper for sel-qualified writes
package wb_user_module_stepper_pkg;

  localparam logic [5:0] OFF_CTRL   = 6'd0;
  localparam logic [5:0] OFF_IN     = 6'd1;
  localparam logic [5:0] OFF_STEP   = 6'd2;
  localparam logic [5:0] OFF_STATUS = 6'd3;
  localparam logic [5:0] OFF_OUT    = 6'd4;

  localparam int ST_BUSY_BIT = 0;
  localparam int ST_CNT_LSB  = 4;
  localparam int ST_CNT_W    = 4;
  localparam int ST_OVF_BIT  = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_user_module_stepper_sync_fifo.sv
// Capture FIFO for module output samples.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   push_i, data_i   write request and data
//   pop_i, data_o    read request; data_o shows the current head
//   full_o, empty_o  occupancy flags
//   count_o          entries held, 0..DEPTH
// A push while full is accepted when a pop happens in the same cycle.
// Pop while empty is ignored.
module wb_user_module_stepper_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  import wb_user_module_stepper_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; empty/count gate every read of it.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wb_user_module_stepper.sv
// Wishbone responder that lets the management SoC drive the user module.
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   wbs_*                Wishbone slave interface (registered single-cycle ack)
//   pad_in               pad inputs, forwarded to the module when EN=0
//   mod_in               module io_in: pad_in, or {IN[MOD_W-1:1], gclk} when EN=1
//   mod_out              module io_out, sampled at the end of each high phase
//   busy_o               a step burst is in progress
//
// state | meaning
// IDLE  | no burst, gclk low, accepts a STEP start
// HIGH  | gclk high for CLK_HALF cycles, captures mod_out on the last one
// LOW   | gclk low for CLK_HALF cycles, then next pulse or IDLE
module wb_user_module_stepper #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          CLK_HALF   = 2,
  parameter int          FIFO_DEPTH = 8,
  parameter int          MOD_W      = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [MOD_W-1:0] pad_in,
  output logic [MOD_W-1:0] mod_in,
  input  logic [MOD_W-1:0] mod_out,
  output logic             busy_o
);
  import wb_user_module_stepper_pkg::*;

  localparam int HC_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_HALF - 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             ack_q;
  logic [31:0]      dat_q;
  logic             en_q;
  logic [MOD_W-1:0] in_q;
  logic             ovf_q, ovf_d;
  logic [1:0]       state_q, state_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic [15:0]      rem_q, rem_d;

  logic             req, hit, acc, wr, rd;
  logic [5:0]       off;
  logic [31:0]      rdata;
  logic [31:0]      ctrl_merged, in_merged, step_merged;
  logic [15:0]      step_cnt;
  logic             step_start;
  logic             gclk;
  logic             capture;
  logic             pop;

  logic [MOD_W-1:0] fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [ST_CNT_W-1:0] cnt_field;

  // Bus decode. ack_q blocks a second request on the ack cycle.
  assign req = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc = req & hit;
  assign wr  = acc & wbs_we_i;
  assign rd  = acc & ~wbs_we_i;
  assign off = wbs_adr_i[7:2];

  assign ctrl_merged = apply_sel({31'b0, en_q}, wbs_dat_i, wbs_sel_i);
  assign in_merged   = apply_sel(32'(in_q), wbs_dat_i, wbs_sel_i);
  // STEP is write-only; unselected lanes contribute zero to the count.
  assign step_merged = apply_sel(32'b0, wbs_dat_i, wbs_sel_i);
  assign step_cnt    = step_merged[15:0];

  assign step_start = wr & (off == OFF_STEP) & (state_q == S_IDLE) & (step_cnt != 16'd0);
  assign gclk       = (state_q == S_HIGH);
  assign capture    = (state_q == S_HIGH) & (hc_q == HC_LAST);
  assign pop        = rd & (off == OFF_OUT) & ~fifo_empty;
  assign busy_o     = (state_q != S_IDLE);

  assign cnt_field = (32'(fifo_count) > 32'((1 << ST_CNT_W) - 1)) ?
                     {ST_CNT_W{1'b1}} : ST_CNT_W'(fifo_count);

  assign mod_in = en_q ? {in_q[MOD_W-1:1], gclk} : pad_in;

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  always_comb begin
    rdata = 32'b0;
    case (off)
      OFF_CTRL:   rdata = {31'b0, en_q};
      OFF_IN:     rdata = 32'(in_q);
      OFF_STATUS: begin
        rdata[ST_BUSY_BIT] = busy_o;
        rdata[ST_CNT_LSB +: ST_CNT_W] = cnt_field;
        rdata[ST_OVF_BIT] = ovf_q;
      end
      OFF_OUT:    rdata = fifo_empty ? 32'b0 : 32'(fifo_head);
      default:    rdata = 32'b0;
    endcase
  end

  // A capture into a full FIFO is only lost when no pop frees a slot.
  always_comb begin
    ovf_d = ovf_q;
    if (wr && (off == OFF_STATUS) && wbs_sel_i[1] && wbs_dat_i[ST_OVF_BIT]) ovf_d = 1'b0;
    if (capture && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (step_start) begin
          rem_d   = step_cnt;
          hc_d    = '0;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (hc_q == HC_LAST) begin
          hc_d    = '0;
          state_d = S_LOW;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      S_LOW: begin
        if (hc_q == HC_LAST) begin
          hc_d    = '0;
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? S_IDLE : S_HIGH;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        hc_d    = '0;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'b0;
      en_q    <= 1'b0;
      in_q    <= '0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      hc_q    <= '0;
      rem_q   <= '0;
    end else begin
      ack_q   <= acc;
      dat_q   <= rd ? rdata : 32'b0;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      hc_q    <= hc_d;
      rem_q   <= rem_d;
      if (wr && (off == OFF_CTRL)) en_q <= ctrl_merged[0];
      if (wr && (off == OFF_IN))   in_q <= in_merged[MOD_W-1:0];
    end
  end

  wb_user_module_stepper_sync_fifo #(
    .WIDTH (MOD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (capture),
    .data_i  (mod_out),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  logic unused_bits;
  assign unused_bits = &{1'b0, wbs_adr_i[1:0], ctrl_merged[31:1],
                         in_merged[31:MOD_W], step_merged[31:16]};

endmodule
